cond_flag_unit: RTL

Consumer-side companion to the datapath ALU. It holds the architectural NZCV flag register and evaluates the 4-bit instruction condition field against the stored flags. It gates the control unit's register-write, memory-write and PC-source strobes and updates the flags from the ALU's N/Z/C/V outputs. It sits between the control decoder and the register file / PC mux of the single-cycle core, and optionally keeps execute/squash performance counters.

---
 rtl/cond_flag_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, condition-field evaluation and strobe predication for the
// single-cycle core. Condition checks use the registered flags only, so an instruction never
// sees the flags it writes itself.
// Optional feature macro: COND_PERF_EN adds saturating execute/squash performance counters
// (exec_cnt, squash_cnt). Without it, cnt_clr is accepted but ignored.
module cond_flag_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs_in,
    input  logic             reg_w_in,
    input  logic             mem_w_in,
    input  logic             cnt_clr,
    output logic             pcsrc,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags
`ifdef COND_PERF_EN
    ,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);

    logic [3:0] flags_q, flags_d;
    logic       cond_pass;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Decode the condition field against the stored flags.
    always_comb begin
        cond_pass = 1'b1;
        unique case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;  // AL (1110 and 1111)
        endcase
    end

    // Predicated strobes: zero latency, still live while reset is high.
    always_comb begin
        cond_ex   = instr_valid && cond_pass;
        pcsrc     = pcs_in && cond_ex;
        reg_write = reg_w_in && cond_ex;
        mem_write = mem_w_in && cond_ex;
    end

    // Next flags: each half loads independently, and only for an executed instruction.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && flag_w[1]) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (cond_ex && flag_w[0]) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    // Flag register; reset discards any update pending in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

`ifdef COND_PERF_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic [CNT_W-1:0] cnt_one;

    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_comb begin
        exec_d   = exec_q;
        squash_d = squash_q;
        if (cnt_clr) begin
            exec_d   = '0;
            squash_d = '0;
        end else begin
            if (cond_ex && (exec_q != {CNT_W{1'b1}})) begin
                exec_d = exec_q + cnt_one;
            end
            if (instr_valid && !cond_pass && (squash_q != {CNT_W{1'b1}})) begin
                squash_d = squash_q + cnt_one;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
`else
    // Counters absent: cnt_clr and the width parameter are intentionally left unused.
    logic unused_cfg;
    assign unused_cfg = cnt_clr ^ (CNT_W == 0);
`endif

endmodule
